// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main control FSM and the cpua datapath.
//   opcode         IR[31:26], stable from DECODE onward
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   pc_source      00 ALU, 01 ALUOut, 10 jump target
//   i_or_d         memory address: 0 PC, 1 ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       IR load enable
//   alu_src_a      0 PC, 1 regA
//   alu_src_b      00 regB, 01 const 4, 10 signext, 11 signext<<2
//   alu_op         00 add, 01 sub, 10 use funct
//   reg_dst        0 rt, 1 rd
//   mem_to_reg     0 ALUOut, 1 MDR
//   reg_write      register file write enable
//   instr_done     one-cycle pulse in the last state of each instruction
//   illegal_op     sticky unsupported-opcode flag
//   state_out      current state encoding, for debug
// master = control FSM side, slave = datapath side.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_out;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, state_out
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op, state_out
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback for the shared-ALU, single-memory datapath.
//   clock  rising-edge system clock
//   reset  asynchronous active-low reset; all outputs forced to 0 while low
//   bus    mc_control_fsm_if.master: opcode/mem_ready in, datapath controls out
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic                   clock,
    input  logic                   reset,
    mc_control_fsm_if.master       bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    state_t state;
    logic   illegal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default: begin
                            state   <= FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                // Opcode is stable, so anything but LW/SW here can only be a
                // corrupted IR; fall back to FETCH rather than wander.
                MEMADR: state <= (bus.opcode == OP_LW) ? MEMRD :
                                 (bus.opcode == OP_SW) ? MEMWR : FETCH;
                MEMRD:  if (bus.mem_ready) state <= MEMWB;
                MEMWR:  if (bus.mem_ready) state <= FETCH;
                EXEC:   state <= RWB;
                ADDIEX: state <= ADDIWB;
                default: state <= FETCH;  // writeback/branch/jump and 12-15
            endcase
        end
    end

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done;
    logic [1:0] pc_source, alu_src_b, alu_op;

    // State decode. Gated by reset so that FETCH's read request does not
    // appear while reset is held. ir_write/pc_write in FETCH and instr_done
    // in MEMWR are qualified by mem_ready so PC/IR stay put while waiting.
    always_comb begin
        pc_write = 1'b0; pc_write_cond = 1'b0; pc_source = 2'b00;
        i_or_d = 1'b0;   mem_read = 1'b0;      mem_write = 1'b0;
        ir_write = 1'b0; alu_src_a = 1'b0;     alu_src_b = 2'b00;
        alu_op = 2'b00;  reg_dst = 1'b0;       mem_to_reg = 1'b0;
        reg_write = 1'b0; instr_done = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read = 1'b1; ir_write = bus.mem_ready;
                    pc_write = bus.mem_ready; alu_src_b = 2'b01;
                end
                DECODE: alu_src_b = 2'b11;
                MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
                MEMRD:  begin mem_read = 1'b1; i_or_d = 1'b1; end
                MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
                MEMWR:  begin mem_write = 1'b1; i_or_d = 1'b1; instr_done = bus.mem_ready; end
                EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
                RWB:    begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
                BRANCH: begin
                    alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1;
                    pc_source = 2'b01; instr_done = 1'b1;
                end
                ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
                ADDIWB: begin reg_write = 1'b1; instr_done = 1'b1; end
                JUMP:   begin pc_write = 1'b1; pc_source = 2'b10; instr_done = 1'b1; end
                default: ;
            endcase
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_source     = pc_source;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_write     = reg_write;
    assign bus.instr_done    = instr_done;
    assign bus.illegal_op    = illegal;
    assign bus.state_out     = state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through
// its state sequence and compares the full control word against hand-written
// values, plus reset, wait-state, illegal-opcode and mid-instruction reset.
module tb_mc_control_fsm;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    mc_control_fsm_if bus();
    mc_control_fsm dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // {pcw, pcwc, pcs[1:0], iord, mr, mw, irw, sa, sb[1:0], op[1:0], rd, m2r, rw, done, ill}
    function automatic logic [17:0] ov(input bit pcw, pcwc, input bit [1:0] pcs,
                                       input bit iord, mr, mw, irw, sa,
                                       input bit [1:0] sb, op,
                                       input bit rd, m2r, rw, done, ill);
        return {pcw, pcwc, pcs, iord, mr, mw, irw, sa, sb, op, rd, m2r, rw, done, ill};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.instr_done, bus.illegal_op};
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [17:0] exp);
        #1;
        n_assert++;
        assert (bus.state_out === st) else begin
            n_fail++;
            $error("FAIL %s state: got %0d want %0d", tag, bus.state_out, st);
        end
        n_assert++;
        assert (obs() === exp) else begin
            n_fail++;
            $error("FAIL %s outputs: got %b want %b", tag, obs(), exp);
        end
    endtask

    // Hand-written control words
    logic [17:0] z, f_wait, f_rdy, dec, madr, mrd, mwb, mwr, mwr_d;
    logic [17:0] exe, rwb, brn, aex, awb, jmp;

    initial begin
        z      = '0;
        f_wait = ov(0,0,2'b00,0,1,0,0,0,2'b01,2'b00,0,0,0,0,0);
        f_rdy  = ov(1,0,2'b00,0,1,0,1,0,2'b01,2'b00,0,0,0,0,0);
        dec    = ov(0,0,2'b00,0,0,0,0,0,2'b11,2'b00,0,0,0,0,0);
        madr   = ov(0,0,2'b00,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0);
        mrd    = ov(0,0,2'b00,1,1,0,0,0,2'b00,2'b00,0,0,0,0,0);
        mwb    = ov(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,1,1,1,0);
        mwr    = ov(0,0,2'b00,1,0,1,0,0,2'b00,2'b00,0,0,0,0,0);
        mwr_d  = ov(0,0,2'b00,1,0,1,0,0,2'b00,2'b00,0,0,0,1,0);
        exe    = ov(0,0,2'b00,0,0,0,0,1,2'b00,2'b10,0,0,0,0,0);
        rwb    = ov(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,0,1,1,0);
        brn    = ov(0,1,2'b01,0,0,0,0,1,2'b00,2'b01,0,0,0,1,0);
        aex    = ov(0,0,2'b00,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0);
        awb    = ov(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0,1,1,0);
        jmp    = ov(1,0,2'b10,0,0,0,0,0,2'b00,2'b00,0,0,0,1,0);

        bus.opcode = 6'h00;
        bus.mem_ready = 1'b1;

        // Reset held 4 cycles, mem_ready high: outputs must still be 0
        repeat (4) tick();
        chk("reset", 4'd0, z);
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        chk("fetch_wait", 4'd0, f_wait);
        tick();
        chk("fetch_wait2", 4'd0, f_wait);

        // LW, mem_ready=1
        bus.opcode = 6'h23; bus.mem_ready = 1'b1;
        chk("lw_fetch", 4'd0, f_rdy);
        tick(); chk("lw_decode", 4'd1, dec);
        tick(); chk("lw_memadr", 4'd2, madr);
        tick(); chk("lw_memrd", 4'd3, mrd);
        tick(); chk("lw_memwb", 4'd4, mwb);
        tick();
        // SW with 3 wait cycles in MEMWR
        bus.opcode = 6'h2B;
        chk("sw_fetch", 4'd0, f_rdy);
        tick(); chk("sw_decode", 4'd1, dec);
        tick(); chk("sw_memadr", 4'd2, madr);
        bus.mem_ready = 1'b0;
        tick(); chk("sw_wr1", 4'd5, mwr);
        tick(); chk("sw_wr2", 4'd5, mwr);
        tick(); chk("sw_wr3", 4'd5, mwr);
        bus.mem_ready = 1'b1;
        chk("sw_wr4", 4'd5, mwr_d);
        tick();
        // R-type
        bus.opcode = 6'h00;
        chk("r_fetch", 4'd0, f_rdy);
        tick(); chk("r_decode", 4'd1, dec);
        tick(); chk("r_exec", 4'd6, exe);
        tick(); chk("r_wb", 4'd7, rwb);
        tick();
        // ADDI
        bus.opcode = 6'h08;
        chk("addi_fetch", 4'd0, f_rdy);
        tick(); chk("addi_decode", 4'd1, dec);
        tick(); chk("addi_ex", 4'd9, aex);
        tick(); chk("addi_wb", 4'd10, awb);
        tick();
        // BEQ
        bus.opcode = 6'h04;
        chk("beq_fetch", 4'd0, f_rdy);
        tick(); chk("beq_decode", 4'd1, dec);
        tick(); chk("beq_branch", 4'd8, brn);
        tick();
        // J
        bus.opcode = 6'h02;
        chk("j_fetch", 4'd0, f_rdy);
        tick(); chk("j_decode", 4'd1, dec);
        tick(); chk("j_jump", 4'd11, jmp);
        tick();
        // Illegal opcode 3F: DECODE -> FETCH, sticky flag
        bus.opcode = 6'h3F;
        chk("ill_fetch", 4'd0, f_rdy);
        tick(); chk("ill_decode", 4'd1, dec);
        tick(); chk("ill_back", 4'd0, f_rdy | 18'd1);
        bus.opcode = 6'h02;
        tick(); chk("ill_sticky_dec", 4'd1, dec | 18'd1);
        tick(); chk("ill_sticky_j", 4'd11, jmp | 18'd1);
        tick();
        // Reset asserted while in MEMRD
        bus.opcode = 6'h23;
        chk("rst_fetch", 4'd0, f_rdy | 18'd1);
        tick(); tick(); tick();
        chk("rst_memrd", 4'd3, mrd | 18'd1);
        reset = 1'b0;
        chk("rst_mid", 4'd0, z);
        tick();
        chk("rst_hold", 4'd0, z);
        reset = 1'b1;
        chk("rst_release", 4'd0, f_rdy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
